// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: valid/ready PC request in, registered instruction word out,
// backed by a read-first synchronous word RAM with a host programming port. Option: IMEM_PARITY_EN.
module imem_fetch_responder #(
   parameter int unsigned DEPTH_LOG2 = 10,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [31:0]           req_pc,
   output logic                  req_ready,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_inst,
   output logic                  rsp_fault,
   input  logic                  prog_we,
   input  logic [DEPTH_LOG2-1:0] prog_addr,
   input  logic [31:0]           prog_data
);

   localparam int unsigned Depth    = 1 << DEPTH_LOG2;
   // 33 bits so the byte span cannot overflow for large DEPTH_LOG2.
   localparam logic [32:0] ByteSpan = 33'd4 << DEPTH_LOG2;

   typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

   state_e                  state_q, state_d;
   logic [31:0]             offset;
   logic                    pc_fault;
   logic                    accept;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic                    fault_q;
   logic [31:0]             mem [Depth];
`ifdef IMEM_PARITY_EN
   logic                    par_mem [Depth];
`endif

   always_comb begin
      offset    = req_pc - BASE_ADDR;
      // Wrap-around subtraction makes a PC below BASE_ADDR land far out of range.
      pc_fault  = (req_pc[1:0] != 2'b00) || ({1'b0, offset} >= ByteSpan);
      req_ready = rst && !prog_we &&
                  ((state_q == StIdle) || ((state_q == StResp) && rsp_ready));
      accept    = req_valid && req_ready;
      rsp_valid = (state_q == StResp);
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: if (accept) state_d = StRead;
         StRead: state_d = StResp;
         StResp: begin
            if (rsp_ready) state_d = accept ? StRead : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         idx_q   <= '0;
         fault_q <= 1'b0;
      end else if (accept) begin
         idx_q   <= offset[DEPTH_LOG2+1:2];
         fault_q <= pc_fault;
      end
   end

   // Output registers load only at the end of READ, so they hold steady through RESP.
   always_ff @(posedge clk) begin
      if (!rst) begin
         rsp_inst  <= NOP_INST;
         rsp_fault <= 1'b0;
      end else if (state_q == StRead) begin
         if (fault_q) begin
            rsp_inst  <= NOP_INST;
            rsp_fault <= 1'b1;
         end else begin
`ifdef IMEM_PARITY_EN
            if ((^mem[idx_q]) != par_mem[idx_q]) begin
               rsp_inst  <= NOP_INST;
               rsp_fault <= 1'b1;
            end else begin
               rsp_inst  <= mem[idx_q];
               rsp_fault <= 1'b0;
            end
`else
            rsp_inst  <= mem[idx_q];
            rsp_fault <= 1'b0;
`endif
         end
      end
   end

   // No reset on storage: program contents survive a core reset.
   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem[prog_addr] <= prog_data;
`ifdef IMEM_PARITY_EN
         par_mem[prog_addr] <= ^prog_data;
`endif
      end
   end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Scoreboard bench for imem_fetch_responder: stimulus pushes expected {fault, inst}, a negedge
// monitor pops and compares on every consumed response.
module tb_imem_fetch_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_pc;
   logic        req_ready;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_inst;
   logic        rsp_fault;
   logic        prog_we;
   logic [9:0]  prog_addr;
   logic [31:0] prog_data;

   int errors = 0;
   int checks = 0;
   logic [32:0] exp_q[$];
   time         pop_t[$];

   localparam logic [31:0] W0  = 32'hA000_0001;
   localparam logic [31:0] W1  = 32'hA000_0002;
   localparam logic [31:0] W2  = 32'hA000_0003;
   localparam logic [31:0] W4  = 32'h0050_0093;
   localparam logic [31:0] WHI = 32'hCAFE_F00D;
   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   imem_fetch_responder dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_pc    (req_pc),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_inst  (rsp_inst),
      .rsp_fault (rsp_fault),
      .prog_we   (prog_we),
      .prog_addr (prog_addr),
      .prog_data (prog_data)
   );

   task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // A response is consumed at the next posedge when valid and ready are both high here.
   always @(negedge clk) begin
      if (rst === 1'b1 && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
         pop_t.push_back($time);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_rsp: got %h with empty scoreboard", {rsp_fault, rsp_inst});
         end else begin
            check("rsp", {rsp_fault, rsp_inst}, exp_q.pop_front());
         end
      end
   end

   task automatic prog(input logic [9:0] a, input logic [31:0] d);
      prog_we = 1'b1;
      prog_addr = a;
      prog_data = d;
      #1;
      check("prog_blocks_ready", {32'b0, req_ready}, 33'd0);
      @(posedge clk); #1;
      prog_we = 1'b0;
   endtask

   // Returns one time unit after the accepting edge.
   task automatic issue(input logic [31:0] pc, input logic [32:0] exp, input bit track);
      int n = 0;
      req_valid = 1'b1;
      req_pc = pc;
      #1;
      while (req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (req_ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: pc %h req_ready %b expected 1", pc, req_ready);
         req_valid = 1'b0;
         return;
      end
      if (track) exp_q.push_back(exp);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("drain", 33'(exp_q.size()), 33'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      req_valid = 1'b0;
      req_pc = '0;
      rsp_ready = 1'b0;
      prog_we = 1'b0;
      prog_addr = '0;
      prog_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rsp_valid", {32'b0, rsp_valid}, 33'd0);
      check("rst_rsp_inst", {1'b0, rsp_inst}, {1'b0, NOP});
      check("rst_rsp_fault", {32'b0, rsp_fault}, 33'd0);
      check("rst_req_ready", {32'b0, req_ready}, 33'd0);
      rst = 1'b1;
      #1;
      check("post_rst_req_ready", {32'b0, req_ready}, 33'd1);
      @(posedge clk); #1;

      prog(10'd0, W0);
      prog(10'd1, W1);
      prog(10'd2, W2);
      prog(10'd4, W4);
      prog(10'd1023, WHI);

      // Latency: idle -> READ at accepting edge, RESP one edge later.
      rsp_ready = 1'b1;
      issue(32'h10, {1'b0, W4}, 1'b1);
      check("lat_read_cycle", {32'b0, rsp_valid}, 33'd0);
      @(posedge clk); #1;
      check("lat_resp_cycle", {32'b0, rsp_valid}, 33'd1);
      drain();

      // Backpressure: response held, no new acceptance.
      rsp_ready = 1'b0;
      issue(32'h4, {1'b0, W1}, 1'b1);
      @(posedge clk); #1;
      for (int i = 0; i < 5; i++) begin
         check("bp_valid", {32'b0, rsp_valid}, 33'd1);
         check("bp_inst", {1'b0, rsp_inst}, {1'b0, W1});
         check("bp_req_ready", {32'b0, req_ready}, 33'd0);
         @(posedge clk); #1;
      end
      rsp_ready = 1'b1;
      issue(32'h0, {1'b0, W0}, 1'b1);
      issue(32'h4, {1'b0, W1}, 1'b1);
      issue(32'h8, {1'b0, W2}, 1'b1);
      drain();
      if (pop_t.size() >= 3) begin
         check("b2b_gap1", 33'(pop_t[pop_t.size()-2] - pop_t[pop_t.size()-3]), 33'd20);
         check("b2b_gap2", 33'(pop_t[pop_t.size()-1] - pop_t[pop_t.size()-2]), 33'd20);
      end else begin
         check("b2b_pops", 33'(pop_t.size()), 33'd3);
      end

      // Faults: misaligned, one past the end, wrapped, and the last valid word.
      issue(32'h2, {1'b1, NOP}, 1'b1);
      issue(32'h1000, {1'b1, NOP}, 1'b1);
      issue(32'hFFFF_FFFC, {1'b1, NOP}, 1'b1);
      issue(32'hFFC, {1'b0, WHI}, 1'b1);
      drain();

      // Write during the READ cycle of the same word returns the old data.
      issue(32'h0, {1'b0, W0}, 1'b1);
      prog(10'd0, 32'hDEAD_BEEF);
      drain();
      issue(32'h0, {1'b0, 32'hDEAD_BEEF}, 1'b1);
      drain();

      // Reset while in READ drops the fetch silently.
      issue(32'h8, 33'd0, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("dropped_no_valid", {32'b0, rsp_valid}, 33'd0);
         @(posedge clk); #1;
      end
      issue(32'h8, {1'b0, W2}, 1'b1);
      issue(32'h10, {1'b0, W4}, 1'b1);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
